// File: rtl/sub8_brent_kung_if.sv
// Operand/result bundle for the pipelined Brent-Kung subtractor.
// master drives operands and control; slave is the subtractor.
interface sub8_brent_kung_if #(
    parameter int unsigned N = 8
);
    logic         iValid;
    logic         iHold;
    logic         iBorrowIn;
    logic [N-1:0] iX;
    logic [N-1:0] iY;
    logic [N-1:0] oZ;
    logic         oBorrowOut;
    logic         oOverflow;
    logic         oZero;
    logic         oReady;

    modport master (
        output iValid, iHold, iBorrowIn, iX, iY,
        input  oZ, oBorrowOut, oOverflow, oZero, oReady
    );

    modport slave (
        input  iValid, iHold, iBorrowIn, iX, iY,
        output oZ, oBorrowOut, oOverflow, oZero, oReady
    );
endinterface

// File: rtl/sub8_brent_kung.sv
// 3-rank pipelined 8-bit subtractor Z = X + ~Y + ~Bin on a Brent-Kung carry tree, with hold and flags.
// Define SUB8_BK_SATURATE_EN to clamp underflowing results to zero.
module sub8_brent_kung (
    input logic              clk,
    input logic              resetn,
    sub8_brent_kung_if.slave bus
);
    localparam int unsigned N  = 8;
    localparam int unsigned NP = 5;

    logic [N-1:0]  xR0, nyR0;
    logic          cinR0, vldR0;

    logic [N-1:0]  gBit, pBit;
    logic          g0c, g10, g32, p32, g54, p54, g76, p76, g30, g74, p74;

    logic [N-1:0]  gR1, sumPR1;
    logic [NP-1:0] pR1;
    logic          cinR1, xMsbR1, yMsbR1, vldR1;

    logic          g5f;
    logic [N:0]    carry;
    logic [N-1:0]  diff, zNext;
    logic          borrowNext, ovfNext;

    logic [N-1:0]  zR2;
    logic          borrowR2, ovfR2, zeroR2, readyR2;

    // R0: capture minuend, inverted subtrahend and inverted borrow-in
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xR0   <= '0;
            nyR0  <= '0;
            cinR0 <= 1'b0;
            vldR0 <= 1'b0;
        end else if (!bus.iHold) begin
            xR0   <= bus.iX;
            nyR0  <= ~bus.iY;
            cinR0 <= ~bus.iBorrowIn;
            vldR0 <= bus.iValid;
        end
    end

    // Prefix levels 1-2; carry-in is folded into the bit-0 generate
    assign gBit = xR0 & nyR0;
    assign pBit = xR0 ^ nyR0;
    assign g0c  = gBit[0] | (pBit[0] & cinR0);
    assign g10  = gBit[1] | (pBit[1] & g0c);
    assign g32  = gBit[3] | (pBit[3] & gBit[2]);
    assign p32  = pBit[3] & pBit[2];
    assign g54  = gBit[5] | (pBit[5] & gBit[4]);
    assign p54  = pBit[5] & pBit[4];
    assign g76  = gBit[7] | (pBit[7] & gBit[6]);
    assign p76  = pBit[7] & pBit[6];
    assign g30  = g32 | (p32 & g10);
    assign g74  = g76 | (p76 & g54);
    assign p74  = p76 & p54;

    // R1: gR1[i] is the partial group generate ending at bit i
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gR1    <= '0;
            pR1    <= '0;
            sumPR1 <= '0;
            cinR1  <= 1'b0;
            xMsbR1 <= 1'b0;
            yMsbR1 <= 1'b0;
            vldR1  <= 1'b0;
        end else if (!bus.iHold) begin
            gR1    <= {g74, gBit[6], g54, gBit[4], g30, gBit[2], g10, g0c};
            pR1    <= {p74, pBit[6], p54, pBit[4], pBit[2]};
            sumPR1 <= pBit;
            cinR1  <= cinR0;
            xMsbR1 <= xR0[N-1];
            yMsbR1 <= ~nyR0[N-1];
            vldR1  <= vldR0;
        end
    end

    // Level 3 (bit 7) plus the fill-in cells for bits 2, 4, 5, 6
    assign g5f   = gR1[5] | (pR1[2] & gR1[3]);
    assign carry = {gR1[7] | (pR1[4] & gR1[3]),
                    gR1[6] | (pR1[3] & g5f),
                    g5f,
                    gR1[4] | (pR1[1] & gR1[3]),
                    gR1[3],
                    gR1[2] | (pR1[0] & gR1[1]),
                    gR1[1],
                    gR1[0],
                    cinR1};

    assign diff       = sumPR1 ^ carry[N-1:0];
    assign borrowNext = ~carry[N];
    assign ovfNext    = (xMsbR1 != yMsbR1) & (diff[N-1] != xMsbR1);

`ifdef SUB8_BK_SATURATE_EN
    assign zNext = borrowNext ? '0 : diff;
`else
    assign zNext = diff;
`endif

    // R2: registered result and flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            zR2      <= '0;
            borrowR2 <= 1'b0;
            ovfR2    <= 1'b0;
            zeroR2   <= 1'b0;
            readyR2  <= 1'b0;
        end else if (!bus.iHold) begin
            zR2      <= zNext;
            borrowR2 <= borrowNext;
            ovfR2    <= ovfNext;
            zeroR2   <= ~|zNext;
            readyR2  <= vldR1;
        end
    end

    assign bus.oZ         = zR2;
    assign bus.oBorrowOut = borrowR2;
    assign bus.oOverflow  = ovfR2;
    assign bus.oZero      = zeroR2;
    assign bus.oReady     = readyR2;
endmodule

// File: tb/tb_sub8_brent_kung.sv
// Self-checking bench for sub8_brent_kung: directed cases plus a random sweep against an arithmetic model.
module tb_sub8_brent_kung;
    typedef struct packed {
        logic       rdy;
        logic [7:0] z;
        logic       b;
        logic       o;
        logic       zr;
    } resT;

    logic clk;
    logic resetn;
    int   nChecks = 0;
    int   nPassed = 0;
    bit   scoreOn = 1'b0;
    resT  pipe [3];
    logic heldEdge;
    resT  seen [$];

    sub8_brent_kung_if bus ();

    sub8_brent_kung dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected result of one operation from plain integer arithmetic
    function automatic resT refSub(input logic v, input logic [7:0] x, input logic [7:0] y,
                                   input logic bin);
        resT r;
        int  d;
        int  sd;
        d  = int'(x) - int'(y) - int'(bin);
        sd = int'($signed(x)) - int'($signed(y)) - int'(bin);
        r.rdy = v;
        r.b   = (d < 0);
        r.z   = 8'(d);
        r.o   = (sd < -128) || (sd > 127);
`ifdef SUB8_BK_SATURATE_EN
        if (r.b) r.z = 8'h00;
`endif
        r.zr  = (r.z == 8'h00);
        return r;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPassed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic resT getSeen(input int idx);
        if (idx < seen.size()) return seen[idx];
        return '0;
    endfunction

    // Reference timeline: an operation accepted on an unheld edge emerges three unheld edges later
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) pipe[i] <= '0;
            heldEdge <= 1'b0;
        end else begin
            heldEdge <= bus.iHold;
            if (!bus.iHold) begin
                pipe[0] <= refSub(bus.iValid, bus.iX, bus.iY, bus.iBorrowIn);
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end
        end
    end

    always @(negedge clk) begin
        if (scoreOn) begin
            checkVal("ready", 32'(bus.oReady), 32'(pipe[2].rdy));
            if (pipe[2].rdy) begin
                checkVal("z",      32'(bus.oZ),         32'(pipe[2].z));
                checkVal("borrow", 32'(bus.oBorrowOut), 32'(pipe[2].b));
                checkVal("ovf",    32'(bus.oOverflow),  32'(pipe[2].o));
                checkVal("zero",   32'(bus.oZero),      32'(pipe[2].zr));
            end
            if (bus.oReady && !heldEdge && resetn)
                seen.push_back({1'b1, bus.oZ, bus.oBorrowOut, bus.oOverflow, bus.oZero});
        end
    end

    task automatic drive(input logic v, input logic h, input logic [7:0] x, input logic [7:0] y,
                         input logic b);
        bus.iValid    = v;
        bus.iHold     = h;
        bus.iX        = x;
        bus.iY        = y;
        bus.iBorrowIn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    initial begin
        int  base;
        resT r;
        logic [7:0] expZ;

        resetn = 1'b0;
        bus.iValid = 1'b0; bus.iHold = 1'b0; bus.iX = '0; bus.iY = '0; bus.iBorrowIn = 1'b0;
        scoreOn = 1'b1;

        // Reset with live stimulus, then release with no valids
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        checkVal("rst_z",      32'(bus.oZ),         32'h0);
        checkVal("rst_borrow", 32'(bus.oBorrowOut), 32'h0);
        checkVal("rst_ovf",    32'(bus.oOverflow),  32'h0);
        checkVal("rst_zero",   32'(bus.oZero),      32'h0);
        checkVal("rst_ready",  32'(bus.oReady),     32'h0);
        resetn = 1'b1;
        idle(4);
        checkVal("post_rst_ready", 32'(bus.oReady), 32'h0);

        // Basic difference
        base = seen.size();
        drive(1'b1, 1'b0, 8'h5A, 8'h1F, 1'b0);
        idle(4);
        r = getSeen(base);
        checkVal("basic_cnt", 32'(seen.size() - base), 32'd1);
        checkVal("basic_z",   32'(r.z),  32'h3B);
        checkVal("basic_b",   32'(r.b),  32'h0);
        checkVal("basic_o",   32'(r.o),  32'h0);
        checkVal("basic_zr",  32'(r.zr), 32'h0);

        // Wrap-around with borrow out
        base = seen.size();
        drive(1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
        idle(4);
        r = getSeen(base);
`ifdef SUB8_BK_SATURATE_EN
        checkVal("wrap_z",  32'(r.z),  32'h00);
        checkVal("wrap_zr", 32'(r.zr), 32'h1);
`else
        checkVal("wrap_z",  32'(r.z),  32'hFF);
        checkVal("wrap_zr", 32'(r.zr), 32'h0);
`endif
        checkVal("wrap_b", 32'(r.b), 32'h1);

        // Signed overflow, then borrow-in reaching zero, back to back
        base = seen.size();
        drive(1'b1, 1'b0, 8'h80, 8'h01, 1'b0);
        drive(1'b1, 1'b0, 8'h10, 8'h0F, 1'b1);
        idle(4);
        checkVal("ovf_cnt", 32'(seen.size() - base), 32'd2);
        r = getSeen(base);
        checkVal("ovf_z", 32'(r.z), 32'h7F);
        checkVal("ovf_o", 32'(r.o), 32'h1);
        r = getSeen(base + 1);
        checkVal("bin_z",  32'(r.z),  32'h00);
        checkVal("bin_zr", 32'(r.zr), 32'h1);
        checkVal("bin_b",  32'(r.b),  32'h0);

        // Streaming with a two-edge hold mid-stream; held-edge operands must be ignored
        base = seen.size();
        drive(1'b1, 1'b0, 8'h09, 8'h03, 1'b0);
        drive(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1);
        drive(1'b1, 1'b1, 8'h13, 8'h77, 1'b0);
        drive(1'b1, 1'b0, 8'h20, 8'h40, 1'b0);
        idle(5);
        checkVal("stream_cnt", 32'(seen.size() - base), 32'd3);
        checkVal("stream_z0", 32'(getSeen(base).z),     32'h06);
        checkVal("stream_z1", 32'(getSeen(base + 1).z), 32'h00);
`ifdef SUB8_BK_SATURATE_EN
        expZ = 8'h00;
`else
        expZ = 8'hE0;
`endif
        checkVal("stream_z2", 32'(getSeen(base + 2).z), 32'(expZ));

        // Hold while a result is presented: outputs freeze, no duplicate result
        base = seen.size();
        drive(1'b1, 1'b0, 8'h33, 8'h11, 1'b0);
        idle(2);
        checkVal("pre_hold_ready", 32'(bus.oReady), 32'h1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
            checkVal("hold_ready", 32'(bus.oReady), 32'h1);
            checkVal("hold_z",     32'(bus.oZ),     32'h22);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        checkVal("after_hold_ready", 32'(bus.oReady), 32'h0);
        checkVal("hold_cnt", 32'(seen.size() - base), 32'd1);

        // Reset with two operations in flight
        drive(1'b1, 1'b0, 8'h70, 8'h10, 1'b0);
        drive(1'b1, 1'b0, 8'h71, 8'h11, 1'b0);
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        base = seen.size();
        idle(5);
        checkVal("flush_cnt", 32'(seen.size() - base), 32'd0);
        drive(1'b1, 1'b0, 8'h44, 8'h04, 1'b0);
        checkVal("lat_e1_ready", 32'(bus.oReady), 32'h0);
        idle(1);
        checkVal("lat_e2_ready", 32'(bus.oReady), 32'h0);
        idle(1);
        checkVal("lat_e3_ready", 32'(bus.oReady), 32'h1);
        checkVal("lat_e3_z",     32'(bus.oZ),     32'h40);
        idle(2);

        // Random sweep with sporadic bubbles and holds
        for (int i = 0; i < 10000; i++)
            drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) == 0),
                  8'($urandom), 8'($urandom), 1'($urandom));
        idle(6);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end
endmodule
